imem_responder: RTL

Instruction-memory responder that serves the core's program-counter fetch requests. It accepts a word address, returns the instruction after a fixed latency with a valid/ready handshake, and drives req_ready, which the fetch stage uses as its stall source (stall = !req_ready). It also exposes a write port for program loading and a flush input for branch/jump redirects.

---
 rtl/imem_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: single outstanding fetch with fixed latency,
// valid/ready response handshake, flush on redirect and a program-load port.
//
// state | meaning
// IDLE  | no request in flight, ready to accept
// WAIT  | request accepted, latency counter running, response not yet visible
// RESP  | response held on resp_* until resp_ready (or flush)
module imem_responder #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        start,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_addr,
    output logic [31:0] resp_instr,
    output logic        resp_err,
    input  logic        flush,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);

    localparam int unsigned IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_count;
    logic [3:0]        w_count_nxt;
    logic [31:0]       r_mem [MEM_WORDS];
    logic [31:0]       r_addr;
    logic [31:0]       r_instr;
    logic              r_err;

    logic              w_accept;
    logic              w_req_err;
    logic [IDX_W-1:0]  w_req_idx;
    logic [31:0]       w_rd_word;
    logic              w_load_ok;
    logic [IDX_W-1:0]  w_load_idx;
    logic              w_unused;

    // Out-of-range is judged on the full word index so high address bits never alias.
    assign w_req_err  = (req_addr[1:0] != 2'b00) ||
                        ({2'b00, req_addr[31:2]} >= MEM_WORDS);
    assign w_req_idx  = req_addr[IDX_W+1:2];
    assign w_rd_word  = r_mem[w_req_idx];

    assign w_load_ok  = ({2'b00, load_addr[31:2]} < MEM_WORDS);
    assign w_load_idx = load_addr[IDX_W+1:2];
    assign w_unused   = ^load_addr[1:0];

    assign req_ready  = start && !flush &&
                        ((r_state == IDLE) || ((r_state == RESP) && resp_ready));
    assign w_accept   = req_valid && req_ready;

    assign resp_valid = (r_state == RESP);
    assign resp_addr  = r_addr;
    assign resp_instr = r_instr;
    assign resp_err   = r_err;

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (flush) begin
            w_state_nxt = IDLE;
            w_count_nxt = 4'd0;
        end else if (w_accept) begin
            if (LATENCY == 1) begin
                w_state_nxt = RESP;
                w_count_nxt = 4'd0;
            end else begin
                w_state_nxt = WAIT;
                w_count_nxt = LAT_M1;
            end
        end else begin
            case (r_state)
                WAIT: begin
                    w_count_nxt = r_count - 4'd1;
                    if (r_count <= 4'd1) begin
                        w_state_nxt = RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            r_state <= IDLE;
            r_count <= 4'd0;
            r_addr  <= 32'd0;
            r_instr <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_instr <= w_req_err ? NOP_INSTR : w_rd_word;
                r_err   <= w_req_err;
            end
        end
    end

    // Storage is deliberately outside the reset domain; the read above samples the old word.
    always_ff @(posedge clk) begin
        if (load_en && w_load_ok) begin
            r_mem[w_load_idx] <= load_data;
        end
    end

endmodule
